// File: rtl/ap_engine.sv
// Bit-serial associative processor: A/B/C word columns plus a per-row carry column.
// Define AP_SUB_EN to enable cmd 5 (SUB, with CY acting as the borrow column).
module ap_engine #(
    parameter int  WORD_SIZE  = 8,
    parameter int  CELL_QUANT = 64,
    localparam int ADDR_W     = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [1:0]           sel_col,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic                 start,
    input  logic [2:0]           cmd,
    output logic                 busy,
    output logic                 ap_state_irq,
    output logic                 ap_err,
    input  logic                 irq_clr
);

    localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

    localparam logic [2:0] CMD_OR  = 3'd0;
    localparam logic [2:0] CMD_XOR = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_NOT = 3'd3;
    localparam logic [2:0] CMD_ADD = 3'd4;
`ifdef AP_SUB_EN
    localparam logic [2:0] CMD_SUB = 3'd5;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic ka;
        logic kb;
        logic kc;
        logic val;
        logic cout;
    } lut_t;

    function automatic logic cmd_legal(input logic [2:0] c);
`ifdef AP_SUB_EN
        return c <= 3'd5;
`else
        return c <= 3'd4;
`endif
    endfunction

    function automatic logic cmd_arith(input logic [2:0] c);
`ifdef AP_SUB_EN
        return (c == CMD_ADD) || (c == CMD_SUB);
`else
        return c == CMD_ADD;
`endif
    endfunction

    // One LUT entry per (cmd, pass): the key to match and the value to write.
    // Arithmetic passes enumerate (a,b,cy); logical passes enumerate (a,b).
    function automatic lut_t lut_row(input logic [2:0] c, input logic [2:0] p);
        lut_t e;
        logic a;
        logic b;
        logic k;
        e = '0;
        if (cmd_arith(c)) begin
            a = p[2];
            b = p[1];
            k = p[0];
        end else begin
            a = p[1];
            b = p[0];
            k = 1'b0;
        end
        e.ka = a;
        e.kb = b;
        e.kc = k;
        case (c)
            CMD_OR:  e.val = a | b;
            CMD_XOR: e.val = a ^ b;
            CMD_AND: e.val = a & b;
            CMD_NOT: e.val = ~a;
            CMD_ADD: begin
                e.val  = a ^ b ^ k;
                e.cout = (a & b) | (a & k) | (b & k);
            end
`ifdef AP_SUB_EN
            CMD_SUB: begin
                e.val  = a ^ b ^ k;
                e.cout = (~a & b) | (~a & k) | (b & k);
            end
`endif
            default: e.val = 1'b0;
        endcase
        return e;
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [2:0]           pass_q, pass_d;
    logic                 busy_q, busy_d;
    logic                 irq_q, irq_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;

    logic [WORD_SIZE-1:0] a_q [CELL_QUANT];
    logic [WORD_SIZE-1:0] a_d [CELL_QUANT];
    logic [WORD_SIZE-1:0] b_q [CELL_QUANT];
    logic [WORD_SIZE-1:0] b_d [CELL_QUANT];
    logic [WORD_SIZE-1:0] c_q [CELL_QUANT];
    logic [WORD_SIZE-1:0] c_d [CELL_QUANT];
    logic                 cy_q [CELL_QUANT];
    logic                 cy_d [CELL_QUANT];
    logic                 cyn_q [CELL_QUANT];
    logic                 cyn_d [CELL_QUANT];
    logic                 tag_q [CELL_QUANT];
    logic                 tag_d [CELL_QUANT];

    logic                 arith;
    logic [2:0]           last_pass;
    logic                 clr_cy;
    logic                 do_cmp;
    logic                 do_wr;
    logic                 commit;
    logic                 host_wr;
    logic                 addr_ok;
    lut_t                 ent;
    logic [WORD_SIZE-1:0] rd_val;

    assign arith     = cmd_arith(cmd_q);
    assign last_pass = arith ? 3'd7 : 3'd3;
    assign addr_ok   = int'(addr_in) < CELL_QUANT;
    assign host_wr   = write_en && !busy_q && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        bit_d   = bit_q;
        pass_d  = pass_q;
        irq_d   = irq_q;
        err_d   = err_q;
        clr_cy  = 1'b0;
        do_cmp  = 1'b0;
        do_wr   = 1'b0;
        commit  = 1'b0;
        if (irq_clr) begin
            irq_d = 1'b0;
            err_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d  = cmd;
                    bit_d  = '0;
                    pass_d = '0;
                    if (cmd_legal(cmd)) begin
                        state_d = S_COMPARE;
                        clr_cy  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                do_cmp  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                do_wr   = 1'b1;
                state_d = S_COMPARE;
                if (pass_q == last_pass) begin
                    pass_d = '0;
                    commit = arith;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    pass_d = pass_q + 3'd1;
                end
            end
            S_DONE: begin
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        cy_d  = cy_q;
        cyn_d = cyn_q;
        tag_d = tag_q;
        ent   = lut_row(cmd_q, pass_q);
        if (host_wr && addr_ok) begin
            unique case (sel_col)
                2'd0:    a_d[addr_in] = data_in;
                2'd1:    b_d[addr_in] = data_in;
                2'd2:    c_d[addr_in] = data_in;
                default: ;
            endcase
        end
        for (int r = 0; r < CELL_QUANT; r++) begin
            if (clr_cy) begin
                cy_d[r] = 1'b0;
            end
            if (do_cmp) begin
                tag_d[r] = (a_q[r][bit_q] == ent.ka)
                         & (b_q[r][bit_q] == ent.kb)
                         & (!arith || (cy_q[r] == ent.kc));
            end
            if (do_wr && tag_q[r]) begin
                c_d[r][bit_q] = ent.val;
                cyn_d[r]      = ent.cout;
            end
            // Last pass tags its own rows on this edge, so bypass cyn_q for them.
            if (commit) begin
                cy_d[r] = tag_q[r] ? ent.cout : cyn_q[r];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            unique case (sel_col)
                2'd0:    rd_val = a_q[addr_in];
                2'd1:    rd_val = b_q[addr_in];
                2'd2:    rd_val = c_q[addr_in];
                default: rd_val[0] = cy_q[addr_in];
            endcase
        end
        data_out_d = read_en ? rd_val : data_out_q;
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            bit_q      <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            bit_q      <= bit_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    // Array storage is intentionally left out of reset.
    always_ff @(posedge CLK100MHZ) begin
        a_q   <= a_d;
        b_q   <= b_d;
        c_q   <= c_d;
        cy_q  <= cy_d;
        cyn_q <= cyn_d;
        tag_q <= tag_d;
    end

    assign data_out     = data_out_q;
    assign busy         = busy_q;
    assign ap_state_irq = irq_q;
    assign ap_err       = err_q;

endmodule

// File: tb/tb_ap_engine.sv
// Self-checking bench for ap_engine: directed test-plan cases plus randomized
// operations checked against a word-level arithmetic model.
module tb_ap_engine;

    localparam int W  = 8;
    localparam int N  = 64;
    localparam int AW = 6;
`ifdef AP_SUB_EN
    localparam int MAXCMD = 5;
`else
    localparam int MAXCMD = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic [W-1:0]  data_in = '0;
    logic [1:0]    sel_col = '0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [W-1:0]  data_out;
    logic          start = 1'b0;
    logic [2:0]    cmd = '0;
    logic          busy;
    logic          irq;
    logic          err;
    logic          irq_clr = 1'b0;

    always #5 clk = ~clk;

    ap_engine #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (
        .CLK100MHZ   (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .sel_col     (sel_col),
        .write_en    (write_en),
        .read_en     (read_en),
        .data_out    (data_out),
        .start       (start),
        .cmd         (cmd),
        .busy        (busy),
        .ap_state_irq(irq),
        .ap_err      (err),
        .irq_clr     (irq_clr)
    );

    logic [W-1:0] ma [N];
    logic [W-1:0] mb [N];
    logic [W-1:0] mc [N];
    logic         mcy [N];
    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int col, input logic [W-1:0] d);
        addr_in  = AW'(a);
        sel_col  = 2'(col);
        data_in  = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input int a, input int col, output logic [W-1:0] d);
        addr_in = AW'(a);
        sel_col = 2'(col);
        read_en = 1'b1;
        tick();
        d       = data_out;
        read_en = 1'b0;
    endtask

    function automatic int exp_cycles(input int c);
        if (c <= 3) return 8 * W + 1;
        if (c <= MAXCMD) return 16 * W + 1;
        return 1;
    endfunction

    // Word-level reference: whole-word operators and integer add/subtract.
    function automatic void model_op(input int c);
        logic [W:0] t;
        for (int r = 0; r < N; r++) begin
            mcy[r] = 1'b0;
            case (c)
                0: mc[r] = ma[r] | mb[r];
                1: mc[r] = ma[r] ^ mb[r];
                2: mc[r] = ma[r] & mb[r];
                3: mc[r] = ~ma[r];
                4: begin
                    t = {1'b0, ma[r]} + {1'b0, mb[r]};
                    mc[r] = t[W-1:0];
                    mcy[r] = t[W];
                end
                default: begin
                    t = {1'b0, ma[r]} - {1'b0, mb[r]};
                    mc[r] = t[W-1:0];
                    mcy[r] = t[W];
                end
            endcase
        end
    endfunction

    task automatic fill_random();
        for (int r = 0; r < N; r++) begin
            ma[r] = W'($urandom);
            mb[r] = W'($urandom);
            wr(r, 0, ma[r]);
            wr(r, 1, mb[r]);
        end
    endtask

    task automatic run_op(input int c, output int n);
        cmd   = 3'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks += 4;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
        if (data_out !== '0) begin
            failures++;
            $display("FAIL reset_data_out got=%h exp=0", data_out);
        end
    endtask

    task automatic test_host_rw();
        logic [W-1:0] d;
        fill_random();
        ma[3] = 8'hA5;
        wr(3, 0, 8'hA5);
        rd(3, 0, d);
        checks++;
        if (d !== 8'hA5) begin
            failures++;
            $display("FAIL rw_a3 got=%h exp=a5", d);
        end
        addr_in = 6'd7;
        sel_col = 2'd1;
        tick();
        checks++;
        if (data_out !== 8'hA5) begin
            failures++;
            $display("FAIL rw_hold got=%h exp=a5", data_out);
        end
        rd(9, 1, d);
        checks++;
        if (d !== mb[9]) begin
            failures++;
            $display("FAIL rw_b9 got=%h exp=%h", d, mb[9]);
        end
    endtask

    task automatic test_xor();
        logic [W-1:0] ea [4] = '{8'hF0, 8'h0F, 8'hAA, 8'hFF};
        logic [W-1:0] eb [4] = '{8'h3C, 8'h3C, 8'h55, 8'h01};
        logic [W-1:0] ec [4] = '{8'hCC, 8'h33, 8'hFF, 8'hFE};
        logic [W-1:0] d;
        int n;
        for (int r = 0; r < 4; r++) begin
            ma[r] = ea[r];
            mb[r] = eb[r];
            wr(r, 0, ea[r]);
            wr(r, 1, eb[r]);
        end
        run_op(1, n);
        checks += 2;
        if (n != 65) begin
            failures++;
            $display("FAIL xor_busy_cycles got=%0d exp=65", n);
        end
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL xor_irq got=%b exp=1", irq);
        end
        for (int r = 0; r < 4; r++) begin
            rd(r, 2, d);
            checks++;
            if (d !== ec[r]) begin
                failures++;
                $display("FAIL xor_c%0d got=%h exp=%h", r, d, ec[r]);
            end
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL xor_irq_clr got=%b exp=0", irq);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] ec [4] = '{8'h2C, 8'h4B, 8'hFF, 8'h00};
        logic         ey [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] d;
        logic [W-1:0] e;
        int n;
        run_op(4, n);
        model_op(4);
        checks++;
        if (n != 129) begin
            failures++;
            $display("FAIL add_busy_cycles got=%0d exp=129", n);
        end
        for (int r = 0; r < 4; r++) begin
            rd(r, 2, d);
            checks++;
            if (d !== ec[r]) begin
                failures++;
                $display("FAIL add_c%0d got=%h exp=%h", r, d, ec[r]);
            end
            rd(r, 3, d);
            e = '0;
            e[0] = ey[r];
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL add_cy%0d got=%h exp=%h", r, d, e);
            end
            rd(r, 0, d);
            checks++;
            if (d !== ma[r]) begin
                failures++;
                $display("FAIL add_a%0d_kept got=%h exp=%h", r, d, ma[r]);
            end
        end
        wr(0, 3, 8'h00);
        rd(0, 3, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL cy_write_dropped got=%h exp=01", d);
        end
    endtask

    task automatic test_random_ops();
        logic [W-1:0] d;
        logic [W-1:0] e;
        int n;
        int c;
        for (int it = 0; it < 5; it++) begin
            fill_random();
            c = (it == 0) ? 4 : $urandom_range(0, MAXCMD);
            run_op(c, n);
            model_op(c);
            checks++;
            if (n != exp_cycles(c)) begin
                failures++;
                $display("FAIL rand_cycles cmd=%0d got=%0d exp=%0d", c, n, exp_cycles(c));
            end
            for (int r = 0; r < N; r++) begin
                rd(r, 2, d);
                checks++;
                if (d !== mc[r]) begin
                    failures++;
                    $display("FAIL rand_c cmd=%0d row=%0d got=%h exp=%h", c, r, d, mc[r]);
                end
                rd(r, 3, d);
                e = '0;
                e[0] = mcy[r];
                checks++;
                if (d !== e) begin
                    failures++;
                    $display("FAIL rand_cy cmd=%0d row=%0d got=%h exp=%h", c, r, d, e);
                end
            end
        end
    endtask

    task automatic test_busy_collisions();
        logic [W-1:0] d;
        int n;
        ma[2] = 8'hAA;
        wr(2, 0, 8'hAA);
        cmd   = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 5000) begin
            n++;
            if (n == 5) begin
                addr_in  = 6'd2;
                sel_col  = 2'd1;
                data_in  = ~mb[2];
                write_en = 1'b1;
                start    = 1'b1;
                cmd      = 3'd2;
            end
            tick();
            write_en = 1'b0;
            start    = 1'b0;
        end
        model_op(3);
        checks++;
        if (n != 65) begin
            failures++;
            $display("FAIL not_busy_cycles got=%0d exp=65", n);
        end
        rd(2, 2, d);
        checks++;
        if (d !== 8'h55) begin
            failures++;
            $display("FAIL not_c2 got=%h exp=55", d);
        end
        rd(2, 1, d);
        checks++;
        if (d !== mb[2]) begin
            failures++;
            $display("FAIL busy_write_dropped got=%h exp=%h", d, mb[2]);
        end
        for (int r = 0; r < N; r += 7) begin
            rd(r, 2, d);
            checks++;
            if (d !== mc[r]) begin
                failures++;
                $display("FAIL not_c row=%0d got=%h exp=%h", r, d, mc[r]);
            end
        end
    endtask

    task automatic test_start_with_write();
        logic [W-1:0] d;
        int n;
        ma[5]    = 8'h3E;
        addr_in  = 6'd5;
        sel_col  = 2'd0;
        data_in  = 8'h3E;
        write_en = 1'b1;
        run_op(1, n);
        write_en = 1'b0;
        model_op(1);
        rd(5, 2, d);
        checks++;
        if (d !== (8'h3E ^ mb[5])) begin
            failures++;
            $display("FAIL start_write_c5 got=%h exp=%h", d, 8'h3E ^ mb[5]);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic test_illegal();
        int n;
        run_op(6, n);
        checks += 3;
        if (n != 1) begin
            failures++;
            $display("FAIL ill_cycles got=%0d exp=1", n);
        end
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL ill_err got=%b exp=1", err);
        end
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL ill_irq got=%b exp=1", irq);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks += 2;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL clr_err got=%b exp=0", err);
        end
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL clr_irq got=%b exp=0", irq);
        end
`ifndef AP_SUB_EN
        run_op(5, n);
        checks += 2;
        if (n != 1) begin
            failures++;
            $display("FAIL cmd5_cycles got=%0d exp=1", n);
        end
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL cmd5_err got=%b exp=1", err);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
`endif
        cmd   = 3'd7;
        start = 1'b1;
        tick();
        start   = 1'b0;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks += 2;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL done_set_wins got=%b exp=1", irq);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL done_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_clr_with_start();
        int n;
        cmd     = 3'd0;
        start   = 1'b1;
        irq_clr = 1'b1;
        tick();
        start   = 1'b0;
        irq_clr = 1'b0;
        checks += 2;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL clr_start_irq got=%b exp=0", irq);
        end
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_start_busy got=%b exp=1", busy);
        end
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
        model_op(0);
        checks += 2;
        if (n != 65) begin
            failures++;
            $display("FAIL clr_start_cycles got=%0d exp=65", n);
        end
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL clr_start_done_irq got=%b exp=1", irq);
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] d;
        int n;
        fill_random();
        cmd   = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_busy got=%b exp=0", busy);
        end
        #1;
        rst = 1'b0;
        for (int r = 0; r < N; r += 9) begin
            rd(r, 0, d);
            checks++;
            if (d !== ma[r]) begin
                failures++;
                $display("FAIL rst_a row=%0d got=%h exp=%h", r, d, ma[r]);
            end
            rd(r, 1, d);
            checks++;
            if (d !== mb[r]) begin
                failures++;
                $display("FAIL rst_b row=%0d got=%h exp=%h", r, d, mb[r]);
            end
        end
        run_op(2, n);
        model_op(2);
        checks++;
        if (n != 65) begin
            failures++;
            $display("FAIL post_rst_and_cycles got=%0d exp=65", n);
        end
        for (int r = 0; r < N; r++) begin
            rd(r, 2, d);
            checks++;
            if (d !== mc[r]) begin
                failures++;
                $display("FAIL post_rst_and row=%0d got=%h exp=%h", r, d, mc[r]);
            end
        end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

`ifdef AP_SUB_EN
    task automatic test_sub();
        logic [W-1:0] d;
        int n;
        ma[0] = 8'h10;
        mb[0] = 8'h01;
        wr(0, 0, 8'h10);
        wr(0, 1, 8'h01);
        run_op(5, n);
        checks++;
        if (n != 129) begin
            failures++;
            $display("FAIL sub_cycles got=%0d exp=129", n);
        end
        rd(0, 2, d);
        checks++;
        if (d !== 8'h0F) begin
            failures++;
            $display("FAIL sub_c0 got=%h exp=0f", d);
        end
        rd(0, 3, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL sub_bw0 got=%h exp=00", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_host_rw();
        test_xor();
        test_add();
        test_random_ops();
        test_busy_collisions();
        test_start_with_write();
        test_illegal();
        test_clr_with_start();
        test_reset_mid_op();
`ifdef AP_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ap_engine.md
Name: ap_engine

Overview:
- Parametrised bit-serial associative processor: three WORD_SIZE-bit columns (A, B, C) over CELL_QUANT rows, plus a one-bit-per-row carry column (CY).
- Executes a LUT-driven compare/write pass sequence over all rows in parallel, one bit position at a time.
- Next generation of the AP slice: adds ADD, a carry column, a start/busy handshake, an illegal-command error and a clearable interrupt.
- Sits behind the host bus as a memory-mapped compute array.

Parameters:
- WORD_SIZE, 8, bits per cell; range 2..32.
- CELL_QUANT, 64, number of rows; need not be a power of two.
- ADDR_W, clogb2(CELL_QUANT), local (not overridable); row address width.

Ports:
- CLK100MHZ  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_in  in  ADDR_W  host row address.
- data_in  in  WORD_SIZE  host write data.
- sel_col  in  2  column select: 0=A, 1=B, 2=C, 3=CY (CY is read-only).
- write_en  in  1  host write strobe.
- read_en  in  1  host read strobe.
- data_out  out  WORD_SIZE  registered read data.
- start  in  1  single-cycle op launch.
- cmd  in  3  operation: 0=OR, 1=XOR, 2=AND, 3=NOT A, 4=ADD (A+B), 5-7 illegal.
- busy  out  1  operation in progress.
- ap_state_irq  out  1  sticky completion interrupt.
- ap_err  out  1  sticky illegal-command flag.
- irq_clr  in  1  clears ap_state_irq and ap_err.

Behaviour:
- Reset values: data_out=0, busy=0, ap_state_irq=0, ap_err=0, FSM=IDLE, bit_cnt=0, pass_cnt=0. Column storage is not reset.
- FSM states: IDLE, COMPARE, WRITE, DONE.
  - IDLE: start=1 latches cmd. A legal cmd goes to COMPARE and clears CY in all rows on the same edge. An illegal cmd goes to DONE and sets ap_err. start=0 holds IDLE.
  - COMPARE: tag[r] = (A[r][bit]==keyA) & (B[r][bit]==keyB) & (ADD ? CY[r]==keyCy : 1). Keys come from the pass LUT indexed by cmd and pass_cnt. Always goes to WRITE.
  - WRITE: for every row with tag[r]=1, C[r][bit] <= LUT value. For ADD, cy_nxt[r] <= LUT carry-out. Increments pass_cnt. On the last pass, CY <= cy_nxt, pass_cnt=0 and bit_cnt++. After the last pass of bit WORD_SIZE-1, goes to DONE; otherwise goes to COMPARE.
  - DONE: sets ap_state_irq, goes to IDLE.
- Pass counts:
  - Logical ops: 4 passes per bit, covering (a,b) = 00, 01, 10, 11.
  - ADD: 8 passes per bit, covering (a,b,cy) = 000..111. sum = a^b^cy; cout = majority(a,b,cy).
  - CY is committed only at the end of a bit, so passes within a bit never see a modified carry.
- Timing:
  - busy is registered. It is 1 from the edge that accepts start until the edge leaving DONE.
  - Logical op: 8*WORD_SIZE+1 busy cycles (65 at W=8). ADD: 16*WORD_SIZE+1 (129).
  - Illegal cmd: 1 busy cycle.
  - ap_state_irq rises on the same edge busy falls.
- After ADD, CY holds the final carry-out per row; A and B are unchanged.
- Host write: accepted only when busy=0 and FSM=IDLE. The cell at (addr_in, sel_col) is updated on the next edge. Writes to sel_col=3 and to addr_in>=CELL_QUANT are dropped.
- Host read: data_out is valid on the edge after read_en.
  - Reads are allowed in any state and return current storage.
  - sel_col=3 returns CY zero-extended.
  - addr_in>=CELL_QUANT returns 0.
  - data_out holds its value when read_en=0.
- Simultaneous events:
  - start while busy is ignored.
  - start together with write_en in IDLE: the write lands first, and the op sees the new value.
  - irq_clr in the same cycle as the DONE set: set wins.
  - irq_clr together with an accepted start: flags clear, and the op proceeds.
- Reset mid-operation: the FSM returns to IDLE immediately and busy drops asynchronously. Partially written C/CY contents are undefined; A and B are untouched.

Optional Feature:
- Macro AP_SUB_EN.
- When defined, cmd 5 = SUB (C = A-B mod 2^W), and CY acts as the borrow column.
  - 8 passes per bit: diff = a^b^bw; bout = (~a&b)|(~a&bw)|(b&bw).
  - CY is cleared at start; same latency as ADD; CY ends holding the final borrow.
- When not defined, cmd 5 is illegal: it sets ap_err and completes in 1 busy cycle.

Test Plan:
- Reset, then read A[0] -> data_out=0, busy=0, ap_state_irq=0, ap_err=0; write A[3]=0xA5, read A[3] -> data_out=0xA5 one cycle later.
- Rows 0..3: A={0xF0,0x0F,0xAA,0xFF}, B={0x3C,0x3C,0x55,0x01}; cmd=1 (XOR) -> busy for exactly 65 cycles, C={0xCC,0x33,0xFF,0xFE}, ap_state_irq=1.
- Same A/B, cmd=4 (ADD) -> busy for 129 cycles, C={0x2C,0x4B,0xFF,0x00}, CY={1,0,0,1}; read sel_col=3 on row 3 -> 0x01.
- cmd=3 (NOT) with A[2]=0xAA -> C[2]=0x55; a write to B during busy is dropped (B readback unchanged); start during busy is ignored.
- cmd=6 -> ap_err=1 and ap_state_irq=1 after 1 busy cycle; irq_clr clears both; irq_clr asserted on the DONE cycle leaves ap_state_irq=1.
- Assert rst at cycle 20 of an ADD -> busy=0 immediately; A/B readback unchanged; a new AND completes normally. With AP_SUB_EN: A=0x10, B=0x01, cmd=5 -> C=0x0F, CY=0.
